// File: rtl/disp_mux_pkg.sv
// Shared reset constants and a constant-evaluable clog2 for the display channel mux.
package disp_mux_pkg;

    localparam logic [31:0] DISP_RST_DATA  = 32'hAA5555AA;
    localparam logic [7:0]  DISP_RST_BLINK = 8'hFF;
    localparam logic [7:0]  DISP_RST_POINT = 8'h00;

    function automatic int unsigned disp_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/disp_scan_timer.sv
// Auto-scan dwell counter and cyclic search for the next enabled channel.
// Compiled only when DISP_AUTOSCAN_EN is defined.
`ifdef DISP_AUTOSCAN_EN
module disp_scan_timer
    import disp_mux_pkg::*;
#(
    parameter int unsigned NCH   = 8,
    parameter int unsigned DWELL = 50_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [disp_clog2(NCH)-1:0]  cur_ch_i,
    input  logic [NCH-1:0]              scan_mask_i,
    input  logic                        active_i,
    output logic                        step_c_o,
    output logic [disp_clog2(NCH)-1:0]  next_ch_c_o
);

    localparam int unsigned SW = disp_clog2(NCH);
    localparam int unsigned CW = disp_clog2(DWELL);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] idx_c;
    logic          found_c;

    // First enabled channel above cur_ch, wrapping; falls back to cur_ch itself.
    always_comb begin
        next_ch_c_o = cur_ch_i;
        found_c     = 1'b0;
        idx_c       = '0;
        for (int i = 1; i <= int'(NCH); i++) begin
            idx_c = SW'((32'(cur_ch_i) + 32'(i)) % NCH);
            if (!found_c && scan_mask_i[idx_c]) begin
                next_ch_c_o = idx_c;
                found_c     = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        step_c_o = 1'b0;
        if (!active_i || (scan_mask_i == '0)) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DWELL - 1)) begin
            cnt_d    = '0;
            step_c_o = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/disp_chan_mux.sv
// Display source selector: channel-0 CPU latch plus live test buses, registered outputs.
// Auto-scan rotation is built only when DISP_AUTOSCAN_EN is defined.
module disp_chan_mux
    import disp_mux_pkg::*;
#(
    parameter int unsigned NCH   = 8,
    parameter int unsigned DW    = 32,
    parameter int unsigned DWELL = 50_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        EN,
    input  logic [disp_clog2(NCH)-1:0]  Test,
    input  logic                        auto,
    input  logic [NCH-1:0]              scan_mask,
    input  logic [DW-1:0]               Data0,
    input  logic [(NCH-1)*DW-1:0]       test_data,
    input  logic [NCH*8-1:0]            point_in,
    input  logic [NCH*8-1:0]            blink_in,
    output logic [DW-1:0]               Disp_num,
    output logic [7:0]                  point_out,
    output logic [7:0]                  blink_out,
    output logic [disp_clog2(NCH)-1:0]  cur_ch,
    output logic                        ch_chg
);

    localparam int unsigned SW = disp_clog2(NCH);

    logic [DW-1:0] d0_q, disp_q, sel_data_c;
    logic [7:0]    p0_q, b0_q, point_q, blink_q, sel_point_c, sel_blink_c;
    logic [SW-1:0] cur_q, next_ch_c, manual_ch_c;
    logic          chg_q;

    // Out-of-range selects (non-power-of-two NCH) fall back to channel 0.
    assign manual_ch_c = (32'(Test) >= NCH) ? '0 : Test;

`ifdef DISP_AUTOSCAN_EN
    logic          step_c;
    logic [SW-1:0] hit_c;

    disp_scan_timer #(
        .NCH   (NCH),
        .DWELL (DWELL)
    ) u_scan_timer (
        .clk         (clk),
        .rst         (rst),
        .cur_ch_i    (cur_q),
        .scan_mask_i (scan_mask),
        .active_i    (auto),
        .step_c_o    (step_c),
        .next_ch_c_o (hit_c)
    );

    always_comb begin
        next_ch_c = manual_ch_c;
        if (auto) begin
            if (scan_mask == '0) begin
                next_ch_c = '0;
            end else if (step_c) begin
                next_ch_c = hit_c;
            end else begin
                next_ch_c = cur_q;
            end
        end
    end
`else
    logic unused_c;
    assign unused_c  = ^{auto, scan_mask, 32'(DWELL)};
    assign next_ch_c = manual_ch_c;
`endif

    // Channel 0 comes from the latched CPU registers, the rest are live.
    always_comb begin
        sel_data_c  = d0_q;
        sel_point_c = p0_q;
        sel_blink_c = b0_q;
        for (int k = 1; k < int'(NCH); k++) begin
            if (next_ch_c == SW'(k)) begin
                sel_data_c  = test_data[(k-1)*DW +: DW];
                sel_point_c = point_in[k*8 +: 8];
                sel_blink_c = blink_in[k*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0_q    <= DW'(DISP_RST_DATA);
            p0_q    <= DISP_RST_POINT;
            b0_q    <= DISP_RST_BLINK;
            disp_q  <= DW'(DISP_RST_DATA);
            point_q <= DISP_RST_POINT;
            blink_q <= DISP_RST_BLINK;
            cur_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            if (EN) begin
                d0_q <= Data0;
                p0_q <= point_in[7:0];
                b0_q <= blink_in[7:0];
            end
            disp_q  <= sel_data_c;
            point_q <= sel_point_c;
            blink_q <= sel_blink_c;
            cur_q   <= next_ch_c;
            chg_q   <= (next_ch_c != cur_q);
        end
    end

    assign Disp_num  = disp_q;
    assign point_out = point_q;
    assign blink_out = blink_q;
    assign cur_ch    = cur_q;
    assign ch_chg    = chg_q;

endmodule
